// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub operation sequencer.
// The state enum is the single source of truth for FSM encoding.
package addsub_pkg;

  localparam int WIDTH_DEF = 6;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

endpackage

// File: rtl/show_timer.sv
// Idle down-counter for the SHOW state: loaded on start, counts while enabled,
// and flags expiry once SHOW_CYCLES enabled cycles have been spent.
module show_timer #(
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic expire
);

  localparam int TW = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD = TW'(SHOW_CYCLES - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Expiry marks the last enabled cycle; the owner acts on the following edge.
  assign expire = enable && (count == '0);

endmodule

// File: rtl/addsub_sequencer.sv
// Single-button sequencer: A entry, B entry, one-cycle execute, result display.
// Operands feed an external combinational ADD/SUB; its result is captured in EXEC.
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             press,
  input  logic [WIDTH-1:0] sw_value,
  input  logic             add_sub,
  input  logic             chain,
  input  logic [WIDTH-1:0] dp_result,
  input  logic             dp_of,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_sel,
  output logic [WIDTH-1:0] result_q,
  output logic             of_q,
  output logic             result_valid,
  output logic             a_led,
  output logic             b_led,
  output logic             busy,
  output logic [7:0]       op_count,
  output state_t           state_dbg
);

  state_t state;
  logic   timer_start;
  logic   timer_enable;
  logic   timer_expire;

  assign timer_start  = (state == EXEC);
  assign timer_enable = (state == SHOW);

  show_timer #(
    .SHOW_CYCLES (SHOW_CYCLES)
  ) u_show_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // result_valid is a level qualifier, not a handshake: result_q/of_q are
  // meaningful exactly while it is high, and the display has no back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ENTER_A;
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= OP_ADD;
      result_q     <= '0;
      of_q         <= 1'b0;
      result_valid <= 1'b0;
      op_count     <= 8'd0;
    end else begin
      case (state)
        ENTER_A: begin
          if (press) begin
            op_a  <= sw_value;
            state <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (press) begin
            op_b   <= sw_value;
            op_sel <= add_sub;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= dp_result;
          of_q         <= dp_of;
          result_valid <= 1'b1;
          if (op_count != 8'hFF) begin
            op_count <= op_count + 8'd1;
          end
          state <= SHOW;
        end
        SHOW: begin
          // A press takes priority over a coincident timeout.
          if (press) begin
            result_valid <= 1'b0;
            if (chain && !of_q) begin
              op_a  <= result_q;
              state <= ENTER_B;
            end else begin
              state <= ENTER_A;
            end
          end else if (timer_expire) begin
            result_valid <= 1'b0;
            state        <= ENTER_A;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

  assign a_led     = (state == ENTER_A);
  assign b_led     = (state == ENTER_B);
  assign busy      = (state == EXEC);
  assign state_dbg = state;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Randomized self-checking bench for addsub_sequencer with a behavioural
// signed-integer model of the add/sub results and an op counter model.
module tb_addsub_sequencer;
  import addsub_pkg::*;

  localparam int W  = 6;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         press;
  logic [W-1:0] sw_value;
  logic         add_sub;
  logic         chain;
  logic [W-1:0] dp_result;
  logic         dp_of;
  logic [W-1:0] op_a, op_b, result_q;
  logic         op_sel, of_q, result_valid, a_led, b_led, busy;
  logic [7:0]   op_count;
  state_t       state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [W:0] exp_q[$];

  addsub_sequencer #(.WIDTH(W), .SHOW_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .press(press), .sw_value(sw_value),
    .add_sub(add_sub), .chain(chain), .dp_result(dp_result), .dp_of(dp_of),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .result_q(result_q),
    .of_q(of_q), .result_valid(result_valid), .a_led(a_led), .b_led(b_led),
    .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // External combinational ADD/SUB datapath
  always_comb begin
    dp_result = op_sel ? (op_a - op_b) : (op_a + op_b);
    dp_of = op_sel ? ((op_a[W-1] != op_b[W-1]) && (dp_result[W-1] != op_a[W-1]))
                   : ((op_a[W-1] == op_b[W-1]) && (dp_result[W-1] != op_a[W-1]));
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    int ai, bi, r;
    logic ovf;
    ai  = int'($signed(a));
    bi  = int'($signed(b));
    r   = sub ? (ai - bi) : (ai + bi);
    ovf = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
    return {ovf, W'(r)};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_press(input logic [W-1:0] v, input logic as, input logic ch);
    @(negedge clk);
    sw_value = v; add_sub = as; chain = ch; press = 1'b1;
    @(negedge clk);
    press = 1'b0;
  endtask

  // Enters A and B from ENTER_A; returns at the negedge inside EXEC.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    drive_press(a, 1'b0, 1'b0);
    drive_press(b, sub, 1'b0);
    exp_q.push_back(model_op(a, b, sub));
    if (exp_count < 255) exp_count++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; press = 1'b0; sw_value = '0; add_sub = 1'b0; chain = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    @(negedge clk);
    checks++; if (a_led !== 1'b1) begin errors++; $display("FAIL reset_a_led got %0b exp 1", a_led); end
    checks++; if ({b_led, busy, result_valid, of_q, op_sel} !== 5'b0) begin errors++; $display("FAIL reset_flags got %05b exp 00000", {b_led, busy, result_valid, of_q, op_sel}); end
    checks++; if ({op_a, op_b, result_q} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", op_a, op_b, result_q); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", op_count); end
  endtask

  task automatic test_basic();
    logic [W:0] e;
    drive_press(6'd5, 1'b0, 1'b0);
    checks++; if (op_a !== 6'd5) begin errors++; $display("FAIL basic_op_a got %0d exp 5", op_a); end
    checks++; if (b_led !== 1'b1) begin errors++; $display("FAIL basic_b_led got %0b exp 1", b_led); end
    drive_press(6'd3, 1'b0, 1'b0);
    exp_q.push_back(model_op(6'd5, 6'd3, 1'b0));
    if (exp_count < 255) exp_count++;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", busy); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got %0b exp 0", busy); end
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL basic_result got %h exp %h", {of_q, result_q}, e); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", result_valid); end
    checks++; if (op_count !== 8'(exp_count)) begin errors++; $display("FAIL basic_count got %0d exp %0d", op_count, exp_count); end
    drive_press(6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [W:0] e;
    drive_op(6'd25, 6'd10, OP_ADD);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL ovf_add got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b1);
    checks++; if ({a_led, b_led, result_valid} !== 3'b100) begin errors++; $display("FAIL ovf_no_chain got %03b exp 100", {a_led, b_led, result_valid}); end
    drive_op(6'b100000, 6'd1, OP_SUB);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL ovf_sub got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b0);
    drive_op(6'd7, 6'd9, OP_SUB);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL neg_sub got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_chain();
    logic [W:0] e;
    drive_op(6'd4, 6'd4, OP_ADD);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL chain_first got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b1);
    checks++; if ({b_led, op_a} !== {1'b1, e[W-1:0]}) begin errors++; $display("FAIL chain_op_a got %h exp %h", {b_led, op_a}, {1'b1, e[W-1:0]}); end
    drive_press(6'd2, OP_SUB, 1'b0);
    exp_q.push_back(model_op(e[W-1:0], 6'd2, OP_SUB));
    if (exp_count < 255) exp_count++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL chain_second got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [W:0] e;
    drive_op(6'd1, 6'd2, OP_ADD);
    @(negedge clk);
    e = exp_q.pop_front();
    for (int i = 1; i < SC; i++) begin
      @(negedge clk);
      checks++; if ({state_dbg == SHOW, result_valid} !== 2'b11) begin errors++; $display("FAIL timeout_early cycle %0d got %02b exp 11", i, {state_dbg == SHOW, result_valid}); end
    end
    @(negedge clk);
    checks++; if ({a_led, result_valid} !== 2'b10) begin errors++; $display("FAIL timeout_expire got %02b exp 10", {a_led, result_valid}); end
    // press exactly on the expiry cycle
    drive_op(6'd3, 6'd4, OP_ADD);
    @(negedge clk);
    e = exp_q.pop_front();
    repeat (SC - 1) @(negedge clk);
    sw_value = 6'd0; chain = 1'b1; press = 1'b1;
    @(negedge clk);
    press = 1'b0; chain = 1'b0;
    checks++; if ({b_led, result_valid, op_a} !== {2'b10, e[W-1:0]}) begin errors++; $display("FAIL timeout_press_wins got %h exp %h", {b_led, result_valid, op_a}, {2'b10, e[W-1:0]}); end
    drive_press(6'd1, OP_ADD, 1'b0);
    exp_q.push_back(model_op(e[W-1:0], 6'd1, OP_ADD));
    if (exp_count < 255) exp_count++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL timeout_chain_result got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_exec_press();
    logic [W:0] e;
    drive_press(6'd11, 1'b0, 1'b0);
    @(negedge clk);
    sw_value = 6'd6; add_sub = OP_SUB; press = 1'b1;
    @(negedge clk);
    sw_value = 6'd20; add_sub = OP_ADD;
    @(negedge clk);
    press = 1'b0;
    exp_q.push_back(model_op(6'd11, 6'd6, OP_SUB));
    if (exp_count < 255) exp_count++;
    e = exp_q.pop_front();
    checks++; if ({state_dbg == SHOW, result_valid, op_b} !== {2'b11, 6'd6}) begin errors++; $display("FAIL exec_press_ignored got %h exp %h", {state_dbg == SHOW, result_valid, op_b}, {2'b11, 6'd6}); end
    checks++; if ({of_q, result_q} !== e) begin errors++; $display("FAIL exec_press_result got %h exp %h", {of_q, result_q}, e); end
    drive_press(6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_exec_reset();
    drive_op(6'd9, 6'd13, OP_SUB);
    void'(exp_q.pop_back());
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exec_reset_in_exec got %0b exp 1", busy); end
    #1 reset = 1'b1;
    #1;
    exp_count = 0;
    checks++; if ({a_led, b_led, busy, result_valid, of_q, op_sel} !== 6'b100000) begin errors++; $display("FAIL exec_reset_flags got %06b exp 100000", {a_led, b_led, busy, result_valid, of_q, op_sel}); end
    checks++; if ({op_a, op_b, result_q, op_count} !== '0) begin errors++; $display("FAIL exec_reset_data got %h %h %h %0d exp 0", op_a, op_b, result_q, op_count); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W:0] e;
    logic [W-1:0] a, b, cur_a;
    logic sub, ch, chained;
    chained = 1'b0;
    cur_a = '0;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      sub = 1'($urandom_range(0, 1));
      if (!chained) begin
        drive_press(a, 1'b0, 1'b0);
        cur_a = a;
      end
      drive_press(b, sub, 1'b0);
      exp_q.push_back(model_op(cur_a, b, sub));
      if (exp_count < 255) exp_count++;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if ({of_q, result_q, result_valid} !== {e, 1'b1}) begin errors++; $display("FAIL rand_result op %0d got %h exp %h", n, {of_q, result_q, result_valid}, {e, 1'b1}); end
      ch = 1'($urandom_range(0, 1));
      drive_press(6'd0, 1'b0, ch);
      chained = ch && !e[W];
      if (chained) begin
        cur_a = e[W-1:0];
        checks++; if ({b_led, op_a} !== {1'b1, cur_a}) begin errors++; $display("FAIL rand_chain op %0d got %h exp %h", n, {b_led, op_a}, {1'b1, cur_a}); end
      end else begin
        checks++; if ({a_led, result_valid} !== 2'b10) begin errors++; $display("FAIL rand_return op %0d got %02b exp 10", n, {a_led, result_valid}); end
      end
    end
    if (chained) begin
      drive_press(6'd0, OP_ADD, 1'b0);
      exp_q.push_back(model_op(cur_a, 6'd0, OP_ADD));
      if (exp_count < 255) exp_count++;
      @(negedge clk);
      void'(exp_q.pop_front());
      drive_press(6'd0, 1'b0, 1'b0);
    end
    checks++; if (op_count !== 8'(exp_count)) begin errors++; $display("FAIL rand_count got %0d exp %0d", op_count, exp_count); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      drive_op(6'(n), 6'd1, OP_ADD);
      @(negedge clk);
      void'(exp_q.pop_front());
      drive_press(6'd0, 1'b0, 1'b0);
      if (n == 253 || n == 254 || n == 259) begin
        checks++; if (op_count !== 8'(exp_count)) begin errors++; $display("FAIL sat_count op %0d got %0d exp %0d", n, op_count, exp_count); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_chain();
    test_timeout();
    test_exec_press();
    test_exec_reset();
    test_random();
    test_exec_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
# addsub_sequencer

Single-button operation sequencer for the 6-bit signed add/subtract datapath. It steps the user through operand A entry, operand B entry, execution and result display. It drives registered operands and the add/sub select into the external ADD/SUB units, then captures their result and overflow one cycle later. It also supports chaining a result back in as the next operand A, and blanks the result after an idle timeout. It sits between the button synchronizer/edge detector and the sign-magnitude/display path.

## Interface
- WIDTH, 6, operand/result width (two's complement)
- SHOW_CYCLES, 50_000_000, idle cycles in SHOW before auto-return to ENTER_A (min 2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- press  in  1  single-cycle synchronized button pulse (from synchronizer)
- sw_value  in  WIDTH  switch operand value
- add_sub  in  1  0 = add, 1 = subtract; sampled at B capture
- chain  in  1  1 = a press in SHOW reuses the result as operand A
- dp_result  in  WIDTH  combinational result from external ADD/SUB mux
- dp_of  in  1  combinational overflow from external ADD/SUB mux
- op_a  out  WIDTH  registered operand A to datapath
- op_b  out  WIDTH  registered operand B to datapath
- op_sel  out  1  registered add/sub select to datapath
- result_q  out  WIDTH  captured result
- of_q  out  1  captured overflow
- result_valid  out  1  result_q/of_q valid for display
- a_led, b_led  out  1  high in ENTER_A / ENTER_B respectively (entry prompt)
- busy  out  1  high in EXEC
- op_count  out  8  completed operations, saturates at 255

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW (one-hot or enum, from package).
- ENTER_A: on press, op_a <= sw_value; go to ENTER_B.
- ENTER_B: on press, op_b <= sw_value and op_sel <= add_sub; go to EXEC.
- EXEC: one cycle, press ignored. result_q <= dp_result; of_q <= dp_of; result_valid <= 1; op_count increments unless already 255. Go to SHOW.
- SHOW with press and chain=1 and of_q=0: op_a <= result_q; result_valid <= 0; go to ENTER_B.
- SHOW with press and (chain=0 or of_q=1): result_valid <= 0; go to ENTER_A. An overflowed result is never chained.
- SHOW without press: the timer counts. At SHOW_CYCLES-1 the block clears result_valid and goes to ENTER_A.
- The timer restarts on every entry into SHOW. If a press and the timeout land in the same cycle, the press wins.
- Outputs in non-SHOW states: result_q/of_q hold their last values, gated only by result_valid.
- Arithmetic is entirely external. The controller never modifies values, and all widths are WIDTH with no extension.

## Timing
- Reset values: state ENTER_A; op_a, op_b, result_q = 0; op_sel, of_q, result_valid, busy, b_led = 0; a_led = 1; op_count = 0; timer = 0.
- Reset asserted mid-operation aborts immediately (asynchronously) to the reset values.
- Press in ENTER_B at edge N: op_b and op_sel are valid after N, with busy = 1 in cycle N+1. result_q, of_q and result_valid are valid after edge N+1. Total latency is 2 edges from the B press to a valid result.
- ADD/SUB is combinational from op_a, op_b and op_sel. dp_result must settle within one cycle.
- a_led, b_led and busy are decoded combinationally from the state register.
- Press pulses wider than one cycle are outside the contract; each high cycle counts as a press.

## Structure
- Package addsub_pkg holds:
  - the state enum type (state_t)
  - the WIDTH default constant
  - the op_sel encodings OP_ADD = 0 and OP_SUB = 1
- Sub-module show_timer holds the SHOW_CYCLES down-counter, with start, enable and expire ports; its width is $clog2(SHOW_CYCLES).
- The existing sync block feeds press; the existing ADD, SUB and mux form the datapath.

## Test plan
- Reset then press with sw=5 → op_a=5 and b_led=1. Press with sw=3, add_sub=0 → busy for 1 cycle. Then result_q=8, of_q=0, result_valid=1, op_count=1.
- A=25, B=10, add → result_q=6'b100011 (-29), of_q=1. A following press with chain=1 goes to ENTER_A (no chaining) and result_valid=0.
- A=-32 (6'b100000), B=1, subtract → of_q=1. Next: A=7, B=9, subtract → result_q=-2 (6'b111110), of_q=0.
- Chain: 4+4=8, then press with chain=1 → op_a=8 in ENTER_B. B=2, subtract → result_q=6.
- SHOW_CYCLES=4, no press → result_valid drops and the state reaches ENTER_A exactly 4 cycles after entering SHOW. A press on the expiry cycle with chain=1 goes to ENTER_B instead.
- Reset asserted in EXEC → all reset values immediately. Press during EXEC → ignored. 256 operations → op_count=255.
